framed_packet_demux: RTL
========================

// Module: framed_packet_demux
// PURPOSE
//  Receive-side framing demux. Takes a decoded byte stream (RX_DATA/RX_VALID) from the lane receive buffer.
//  Strips the control symbols STP, SDP, END, IDL and PAD.
//  Routes payload opened by STP to the TLP channel and payload opened by SDP to the DLLP channel.
//  Each channel has its own FIFO with a valid/ready/last interface. Framing violations are flagged.
// PARAMETERS
//  DATA_W      8     symbol/data width in bits
//  FIFO_DEPTH  8     entries per channel FIFO; power of two, >=2
//  STP_SYM     8'hFB start-TLP symbol
//  SDP_SYM     8'h5C start-DLLP symbol
//  END_SYM     8'hFD end-of-packet symbol
//  IDL_SYM     8'h7C idle symbol
//  PAD_SYM     8'hF7 pad symbol
// PORTS
//  CLK         in  1       clock; all logic on posedge
//  RESET_L     in  1       asynchronous, active-low reset
//  RX_DATA     in  DATA_W  received symbol
//  RX_VALID    in  1       RX_DATA valid this cycle; no backpressure on input
//  TLP_DATA    out DATA_W  TLP channel FIFO head
//  TLP_LAST    out 1       head byte is last of its packet
//  TLP_VALID   out 1       TLP FIFO non-empty
//  TLP_READY   in  1       TLP consumer pops head when VALID&READY
//  DLLP_DATA   out DATA_W  DLLP channel FIFO head
//  DLLP_LAST   out 1       head byte is last of its packet
//  DLLP_VALID  out 1       DLLP FIFO non-empty
//  DLLP_READY  in  1       DLLP consumer pop
//  FRAME_ERR   out 1       one-cycle pulse on a framing violation
//  OVERFLOW    out 2       sticky FIFO-full drop flags; [0]=TLP, [1]=DLLP
// BEHAVIOUR
//  Reset (async assert, sync release):
//   FSM=IDLE, pending reg empty, both FIFOs empty.
//   All *_VALID, *_LAST, *_DATA, FRAME_ERR and OVERFLOW = 0.
//  Cycles with RX_VALID=0: no state change; FIFO pops still occur.
//  FSM states: IDLE, IN_TLP, IN_DLLP.
//   IDLE:   STP->IN_TLP; SDP->IN_DLLP; IDL/PAD/data dropped silently; END->FRAME_ERR, stay IDLE.
//   IN_x:   data byte->push pending (LAST=0) if present, then new byte becomes pending.
//           END->push pending with LAST=1, go IDLE.
//           END with no pending (empty packet)->FRAME_ERR, go IDLE, nothing written.
//           STP/SDP->push pending with LAST=1, FRAME_ERR, enter new state (new packet starts).
//           IDL/PAD->push pending with LAST=1, FRAME_ERR, go IDLE.
//  Pending reg: one DATA_W entry plus owning channel. It lets LAST mark the final payload byte without lookahead.
//  Latency: a payload byte is written to its FIFO on the edge that accepts the next payload byte, or END.
//   *_VALID rises the following cycle (registered FIFO outputs, first-word fall-through).
//  Per-packet output is byte-exact; control symbols never reach a FIFO.
//  FIFO: circular pointers of log2(FIFO_DEPTH)+1 bits; full/empty from MSB compare; wrap-around is transparent.
//   Push and pop in the same cycle are both honoured, including when full (occupancy unchanged).
//   Push to a full FIFO without a pop: byte (and its LAST) dropped; OVERFLOW[ch] set until reset.
//   Packet framing of the other channel is unaffected.
//  FRAME_ERR: high exactly one cycle per violating symbol; never high at reset.
//  Reset mid-packet: FSM, pending reg and FIFO contents are discarded; outputs return to reset values immediately.
// TESTING
//  1 STP,11,22,33,END -> TLP pops 11/0,22/0,33/1 (DATA/LAST); DLLP_VALID stays 0; FRAME_ERR never 1.
//  2 SDP,A1,A2,END with IDL/PAD between packets -> DLLP gets A1/0,A2/1; no IDL/PAD bytes appear; no error.
//  3 STP,01,SDP,02,END -> TLP gets 01/1; FRAME_ERR pulse on the SDP cycle; DLLP gets 02/1.
//  4 END in IDLE, then STP,END -> two FRAME_ERR pulses; both FIFOs stay empty.
//  5 TLP_READY=0, 12-byte TLP with FIFO_DEPTH=8 -> first 8 bytes kept, rest dropped; OVERFLOW=2'b01 until reset.
//  6 Full FIFO with READY=1 and a write in the same cycle -> occupancy stays 8, no OVERFLOW.
//    Separately, RESET_L low mid-packet -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/framed_packet_demux_if.sv
// Bundle of the receive symbol stream and the two framed output channels.
// The demux takes the slave view; the producer/consumer side takes the master view.
interface framed_packet_demux_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_VALID;
    logic [DATA_W-1:0] TLP_DATA;
    logic              TLP_LAST;
    logic              TLP_VALID;
    logic              TLP_READY;
    logic [DATA_W-1:0] DLLP_DATA;
    logic              DLLP_LAST;
    logic              DLLP_VALID;
    logic              DLLP_READY;
    logic              FRAME_ERR;
    logic [1:0]        OVERFLOW;

    modport slave (
        input  RX_DATA, RX_VALID, TLP_READY, DLLP_READY,
        output TLP_DATA, TLP_LAST, TLP_VALID, DLLP_DATA, DLLP_LAST, DLLP_VALID,
        output FRAME_ERR, OVERFLOW
    );

    modport master (
        output RX_DATA, RX_VALID, TLP_READY, DLLP_READY,
        input  TLP_DATA, TLP_LAST, TLP_VALID, DLLP_DATA, DLLP_LAST, DLLP_VALID,
        input  FRAME_ERR, OVERFLOW
    );
endinterface

// File: rtl/framed_packet_demux.sv
// Receive framing demux: strips STP/SDP/END/IDL/PAD and steers payload into per-channel
// FIFOs, holding one byte back so the final byte of a packet can be tagged LAST.
module framed_packet_demux #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] STP_SYM    = 8'hFB,
    parameter logic [DATA_W-1:0] SDP_SYM    = 8'h5C,
    parameter logic [DATA_W-1:0] END_SYM    = 8'hFD,
    parameter logic [DATA_W-1:0] IDL_SYM    = 8'h7C,
    parameter logic [DATA_W-1:0] PAD_SYM    = 8'hF7
) (
    input logic                  CLK,
    input logic                  RESET_L,
    framed_packet_demux_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_W + 1;
    localparam logic [AW:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StInTlp, StInDllp} state_e;

    state_e            state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              pend_ch_q, pend_ch_d;
    logic              frame_err_q, frame_err_d;
    logic              push, push_last;
    logic [1:0]        push_sel;

    logic              is_stp, is_sdp, is_end, is_ctrl;

    logic [EW-1:0]     mem_q [2][FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q [2];
    logic [AW:0]       rd_ptr_q [2];
    logic [EW-1:0]     head [2];
    logic [1:0]        empty, full, pop, wr_en, drop, ready;
    logic [1:0]        ovf_q;

    assign is_stp  = bus.RX_DATA == STP_SYM;
    assign is_sdp  = bus.RX_DATA == SDP_SYM;
    assign is_end  = bus.RX_DATA == END_SYM;
    assign is_ctrl = is_stp | is_sdp | is_end | (bus.RX_DATA == IDL_SYM) |
                     (bus.RX_DATA == PAD_SYM);

    always_comb begin
        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        pend_ch_d   = pend_ch_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        push_last   = 1'b0;
        if (bus.RX_VALID) begin
            unique case (state_q)
                StIdle: begin
                    if (is_stp) begin
                        state_d = StInTlp;
                    end else if (is_sdp) begin
                        state_d = StInDllp;
                    end else if (is_end) begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    if (is_ctrl) begin
                        // Any control symbol closes the packet; only END after payload is clean.
                        push        = pend_vld_q;
                        push_last   = 1'b1;
                        pend_vld_d  = 1'b0;
                        frame_err_d = !(is_end && pend_vld_q);
                        state_d     = is_stp ? StInTlp : (is_sdp ? StInDllp : StIdle);
                    end else begin
                        push        = pend_vld_q;
                        pend_vld_d  = 1'b1;
                        pend_data_d = bus.RX_DATA;
                        pend_ch_d   = (state_q == StInDllp);
                    end
                end
            endcase
        end
    end

    assign push_sel = push ? (pend_ch_q ? 2'b10 : 2'b01) : 2'b00;
    assign ready    = {bus.DLLP_READY, bus.TLP_READY};

    always_comb begin
        empty = '0;
        full  = '0;
        pop   = '0;
        wr_en = '0;
        drop  = '0;
        for (int c = 0; c < 2; c++) begin
            empty[c] = wr_ptr_q[c] == rd_ptr_q[c];
            full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                       (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
            pop[c]   = !empty[c] && ready[c];
            // A pop on the same edge frees the slot, so a full FIFO still accepts.
            wr_en[c] = push_sel[c] && (!full[c] || pop[c]);
            drop[c]  = push_sel[c] && full[c] && !pop[c];
            head[c]  = mem_q[c][rd_ptr_q[c][AW-1:0]];
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= StIdle;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            pend_ch_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= '0;
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            pend_ch_q   <= pend_ch_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_q | drop;
            for (int c = 0; c < 2; c++) begin
                if (wr_en[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PtrOne;
                if (pop[c])   rd_ptr_q[c] <= rd_ptr_q[c] + PtrOne;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int c = 0; c < 2; c++) begin
            if (wr_en[c]) mem_q[c][wr_ptr_q[c][AW-1:0]] <= {push_last, pend_data_q};
        end
    end

    // Storage is not reset, so head outputs are masked while the FIFO is empty.
    assign bus.TLP_VALID  = !empty[0];
    assign bus.TLP_DATA   = empty[0] ? '0 : head[0][DATA_W-1:0];
    assign bus.TLP_LAST   = !empty[0] && head[0][DATA_W];
    assign bus.DLLP_VALID = !empty[1];
    assign bus.DLLP_DATA  = empty[1] ? '0 : head[1][DATA_W-1:0];
    assign bus.DLLP_LAST  = !empty[1] && head[1][DATA_W];
    assign bus.FRAME_ERR  = frame_err_q;
    assign bus.OVERFLOW   = ovf_q;
endmodule
